// File: rtl/fir_tap_sequencer.sv
// ---------------------------------------------------------------------------
// fir_tap_sequencer
//
// Control stage in front of the FIR core's shared multiply/add ALU. Holds the
// sample delay line and the coefficient bank, accepts one sample per
// handshake, issues one signed multiply per tap to the ALU, accumulates the
// returned products and emits y[n] = sum c[k]*x[n-k].
//
// Ports
//   clk         system clock, rising edge
//   rst         synchronous active-low reset
//   coef_we     coefficient write strobe (honoured only while idle)
//   coef_addr   coefficient index k
//   coef_wdata  coefficient value (signed)
//   in_valid    input sample valid
//   in_data     input sample x[n] (signed)
//   in_ready    block can accept a sample (IDLE and not in reset)
//   alu_a       multiplier operand: sample x[k]
//   alu_b       multiplier operand: coefficient c[k]
//   alu_op_sel  2'b01 while issuing multiplies, 2'b00 otherwise
//   alu_result  ALU product, valid ALU_LAT cycles after issue
//   out_valid   one-cycle pulse when out_data is new
//   out_data    filter output, held until the next out_valid
//   busy        high in every state other than IDLE
// ---------------------------------------------------------------------------
module fir_tap_sequencer #(
  parameter int NTAPS   = 16,
  parameter int DW      = 16,
  parameter int AW      = 32,
  parameter int ALU_LAT = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     coef_we,
  input  logic [$clog2(NTAPS)-1:0] coef_addr,
  input  logic [DW-1:0]            coef_wdata,
  input  logic                     in_valid,
  input  logic [DW-1:0]            in_data,
  output logic                     in_ready,
  output logic [DW-1:0]            alu_a,
  output logic [DW-1:0]            alu_b,
  output logic [1:0]               alu_op_sel,
  input  logic [AW-1:0]            alu_result,
  output logic                     out_valid,
  output logic [AW-1:0]            out_data,
  output logic                     busy
);

  localparam int CW  = $clog2(NTAPS);
  localparam int DCW = (ALU_LAT > 1) ? $clog2(ALU_LAT) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t          r_state;
  state_t          w_state_next;

  logic [DW-1:0]   r_x [NTAPS];
  logic [DW-1:0]   r_c [NTAPS];
  logic [CW-1:0]   r_tap;
  logic [DCW-1:0]  r_drain;
  logic [ALU_LAT-1:0] r_tag;
  logic [AW-1:0]   r_acc;
  logic [AW-1:0]   r_out_data;
  logic            r_out_valid;
  logic [DW-1:0]   r_alu_a;
  logic [DW-1:0]   r_alu_b;
  logic [1:0]      r_alu_op;

  logic            w_accept;
  logic            w_coef_wr;
  logic            w_last_tap;
  logic            w_last_drain;
  logic [CW-1:0]   w_tap_next;
  logic [DW-1:0]   w_coef0;
  logic [AW-1:0]   w_acc_next;

  // ---------------------------------------------------------------------
  // Control
  // ---------------------------------------------------------------------
  always_comb begin
    w_state_next = r_state;
    w_accept     = 1'b0;
    w_last_tap   = (r_state == S_ISSUE) && (r_tap == CW'(NTAPS - 1));
    w_last_drain = (r_state == S_DRAIN) && (r_drain == DCW'(ALU_LAT - 1));
    w_coef_wr    = coef_we && (r_state == S_IDLE) && (int'(coef_addr) < NTAPS);
    w_tap_next   = r_tap + CW'(1);
    // Operands for tap 0 are registered on the accept edge, so a same-cycle
    // write to c[0] has to be forwarded rather than read from the bank.
    w_coef0      = (w_coef_wr && (coef_addr == '0)) ? coef_wdata : r_c[0];
    w_acc_next   = r_tag[ALU_LAT-1] ? (r_acc + alu_result) : r_acc;

    case (r_state)
      S_IDLE: begin
        if (in_valid) begin
          w_accept     = 1'b1;
          w_state_next = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (w_last_tap) begin
          w_state_next = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (w_last_drain) begin
          w_state_next = S_DONE;
        end
      end
      S_DONE: begin
        w_state_next = S_IDLE;
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // ---------------------------------------------------------------------
  // Datapath
  // ---------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int unsigned k = 0; k < NTAPS; k++) begin
        r_x[k] <= '0;
        r_c[k] <= '0;
      end
      r_tap       <= '0;
      r_drain     <= '0;
      r_tag       <= '0;
      r_acc       <= '0;
      r_out_data  <= '0;
      r_out_valid <= 1'b0;
      r_alu_a     <= '0;
      r_alu_b     <= '0;
      r_alu_op    <= '0;
    end else begin
      if (w_coef_wr) begin
        r_c[coef_addr] <= coef_wdata;
      end

      // Tag marks which cycles carry a product on alu_result.
      r_tag[0] <= (r_state == S_ISSUE);
      for (int unsigned i = 1; i < ALU_LAT; i++) begin
        r_tag[i] <= r_tag[i-1];
      end

      r_acc       <= w_acc_next;
      r_out_valid <= w_last_drain;
      // The final product lands on the same edge that leaves DRAIN, so the
      // output takes the post-add value.
      if (w_last_drain) begin
        r_out_data <= w_acc_next;
      end

      // Operands are registered one cycle ahead of the ISSUE cycle that
      // presents them.
      if (w_accept) begin
        for (int unsigned k = 1; k < NTAPS; k++) begin
          r_x[k] <= r_x[k-1];
        end
        r_x[0]   <= in_data;
        r_acc    <= '0;
        r_tap    <= '0;
        r_alu_a  <= in_data;
        r_alu_b  <= w_coef0;
        r_alu_op <= 2'b01;
      end else if (r_state == S_ISSUE) begin
        if (w_last_tap) begin
          r_alu_a  <= '0;
          r_alu_b  <= '0;
          r_alu_op <= 2'b00;
          r_drain  <= '0;
        end else begin
          r_tap    <= w_tap_next;
          r_alu_a  <= r_x[w_tap_next];
          r_alu_b  <= r_c[w_tap_next];
        end
      end else if (r_state == S_DRAIN) begin
        r_drain <= r_drain + DCW'(1);
      end
    end
  end

  assign in_ready   = (r_state == S_IDLE) && rst;
  assign busy       = (r_state != S_IDLE);
  assign alu_a      = r_alu_a;
  assign alu_b      = r_alu_b;
  assign alu_op_sel = r_alu_op;
  assign out_valid  = r_out_valid;
  assign out_data   = r_out_data;

endmodule

// File: tb/tb_fir_tap_sequencer.sv
module tb_fir_tap_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        coef_we;
  logic [3:0]  coef_addr;
  logic [15:0] coef_wdata;
  logic        in_valid;
  logic [15:0] in_data;

  logic        rdy16, ov16, busy16;
  logic [15:0] a16, b16;
  logic [1:0]  op16;
  logic [31:0] res16, od16;

  logic        rdy12, ov12, busy12;
  logic [15:0] a12, b12;
  logic [1:0]  op12;
  logic [31:0] res12, od12;

  always #5 clk = ~clk;

  fir_tap_sequencer #(.NTAPS(16), .DW(16), .AW(32), .ALU_LAT(2)) dut (
    .clk(clk), .rst(rst), .coef_we(coef_we), .coef_addr(coef_addr),
    .coef_wdata(coef_wdata), .in_valid(in_valid), .in_data(in_data),
    .in_ready(rdy16), .alu_a(a16), .alu_b(b16), .alu_op_sel(op16),
    .alu_result(res16), .out_valid(ov16), .out_data(od16), .busy(busy16)
  );

  fir_tap_sequencer #(.NTAPS(12), .DW(16), .AW(32), .ALU_LAT(2)) dut12 (
    .clk(clk), .rst(rst), .coef_we(coef_we), .coef_addr(coef_addr),
    .coef_wdata(coef_wdata), .in_valid(in_valid), .in_data(in_data),
    .in_ready(rdy12), .alu_a(a12), .alu_b(b12), .alu_op_sel(op12),
    .alu_result(res12), .out_valid(ov12), .out_data(od12), .busy(busy12)
  );

  // Two-stage signed multiplier; non-multiply cycles return junk so that
  // mistimed accumulation shows up in the sums.
  logic [31:0] p16 [2];
  logic [31:0] p12 [2];
  always @(posedge clk) begin
    p16[0] <= (op16 == 2'b01) ?
      32'($signed({{16{a16[15]}}, a16}) * $signed({{16{b16[15]}}, b16})) : 32'hDEADBEEF;
    p16[1] <= p16[0];
    p12[0] <= (op12 == 2'b01) ?
      32'($signed({{16{a12[15]}}, a12}) * $signed({{16{b12[15]}}, b12})) : 32'hDEADBEEF;
    p12[1] <= p12[0];
  end
  assign res16 = p16[1];
  assign res12 = p12[1];

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;
  logic        sel_small = 1'b0;
  int unsigned n_ov16 = 0;
  int unsigned n_ov12 = 0;
  int unsigned n_acc16 = 0;
  logic [31:0] outq16 [$];

  always @(negedge clk) begin
    if (rst) begin
      if (ov16) begin
        n_ov16++;
        outq16.push_back(od16);
      end
      if (ov12) n_ov12++;
      if (in_valid && rdy16) n_acc16++;
    end
  end

  typedef struct {
    logic [1:0]  bank;
    logic [15:0] din;
    logic [31:0] exp;
  } vec_t;
  vec_t tbl [34];

  function automatic logic f_rdy();
    return sel_small ? rdy12 : rdy16;
  endfunction
  function automatic logic f_ov();
    return sel_small ? ov12 : ov16;
  endfunction
  function automatic logic [31:0] f_od();
    return sel_small ? od12 : od16;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_errors++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  task automatic do_reset();
    rst = 1'b0;
    in_valid = 1'b0;
    coef_we = 1'b0;
    tick();
    tick();
    rst = 1'b1;
  endtask

  task automatic wr_coef(input int unsigned addr, input logic [15:0] data);
    coef_we = 1'b1;
    coef_addr = 4'(addr);
    coef_wdata = data;
    tick();
    coef_we = 1'b0;
  endtask

  task automatic load_bank(input logic [1:0] bank);
    for (int k = 0; k < 16; k++) begin
      case (bank)
        2'd0:    wr_coef(k, 16'(k + 1));
        2'd1:    wr_coef(k, 16'h7FFF);
        default: wr_coef(k, (k == 0) ? 16'hFFFE : 16'h0000);
      endcase
    end
  endtask

  // Sends one sample, waits for its output, checks value, latency, that
  // in_ready stayed low, that out_valid is a single pulse and data holds.
  task automatic apply_sample(input logic [15:0] d, input logic [31:0] exp, input string tag);
    int unsigned lat_req;
    int unsigned lat;
    int unsigned t;
    logic        found;
    logic        rdy_seen;
    lat_req = sel_small ? 15 : 19;
    t = 0;
    while (!f_rdy() && t < 50) begin
      tick();
      t++;
    end
    check($sformatf("%s ready", tag), 32'(f_rdy()), 32'd1);
    in_data = d;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    lat = 1;
    found = 1'b0;
    rdy_seen = 1'b0;
    for (int n = 0; n < 40; n++) begin
      if (f_ov()) begin
        found = 1'b1;
        break;
      end
      rdy_seen |= f_rdy();
      tick();
      lat++;
    end
    check($sformatf("%s out_valid_seen", tag), 32'(found), 32'd1);
    check($sformatf("%s latency", tag), lat, lat_req);
    check($sformatf("%s out_data", tag), f_od(), exp);
    check($sformatf("%s in_ready_low", tag), 32'(rdy_seen), 32'd0);
    tick();
    check($sformatf("%s pulse_end", tag), 32'(f_ov()), 32'd0);
    check($sformatf("%s hold", tag), f_od(), exp);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog timeout actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] got;
    int unsigned base;

    for (int k = 0; k < 16; k++) begin
      tbl[k]      = '{bank: 2'd0, din: (k == 0) ? 16'd1 : 16'd0, exp: 32'(k + 1)};
      tbl[16 + k] = '{bank: 2'd1, din: 16'h7FFF, exp: 32'(k + 1) * 32'h3FFF0001};
    end
    tbl[31] = '{bank: 2'd1, din: 16'h7FFF, exp: 32'hFFF00010};
    tbl[32] = '{bank: 2'd2, din: 16'hFFFD, exp: 32'd6};
    tbl[33] = '{bank: 2'd2, din: 16'd5,    exp: 32'hFFFFFFF6};

    rst = 1'b0;
    coef_we = 1'b0;
    coef_addr = '0;
    coef_wdata = '0;
    in_valid = 1'b0;
    in_data = '0;

    // Reset state
    tick();
    tick();
    check("rst in_ready", 32'(rdy16), 32'd0);
    check("rst busy", 32'(busy16), 32'd0);
    check("rst busy12", 32'(busy12), 32'd0);
    check("rst out_valid", 32'(ov16), 32'd0);
    check("rst out_data", od16, 32'd0);
    check("rst alu_op_sel", 32'(op16), 32'd0);
    check("rst alu_a", 32'(a16), 32'd0);
    check("rst alu_b", 32'(b16), 32'd0);
    rst = 1'b1;
    #1;
    check("post-rst in_ready", 32'(rdy16), 32'd1);

    // Table: impulse, overflow wrap, signed
    for (int i = 0; i < 34; i++) begin
      if (i == 0 || tbl[i].bank != tbl[i-1].bank) begin
        do_reset();
        load_bank(tbl[i].bank);
      end
      apply_sample(tbl[i].din, tbl[i].exp, $sformatf("vec%0d", i));
    end

    // Backpressure with held in_valid, and coefficient lockout while busy
    do_reset();
    load_bank(2'd0);
    outq16.delete();
    n_acc16 = 0;
    in_data = 16'd7;
    in_valid = 1'b1;
    for (int i = 0; i < 60; i++) begin
      if (i == 4) begin
        coef_we = 1'b1;
        coef_addr = 4'd0;
        coef_wdata = 16'd100;
      end else begin
        coef_we = 1'b0;
      end
      tick();
    end
    in_valid = 1'b0;
    check("bp accepts", n_acc16, 32'd3);
    check("bp outputs", 32'(outq16.size()), 32'd3);
    got = (outq16.size() > 0) ? outq16[0] : 'x;
    check("bp out0", got, 32'd7);
    got = (outq16.size() > 1) ? outq16[1] : 'x;
    check("bp out1", got, 32'd21);
    got = (outq16.size() > 2) ? outq16[2] : 'x;
    check("bp out2", got, 32'd42);
    apply_sample(16'd1, 32'd64, "lockout");

    // Reset in the 5th ISSUE cycle
    do_reset();
    load_bank(2'd0);
    base = n_ov16;
    in_data = 16'd5;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    check("mid tap0 alu_a", 32'(a16), 32'd5);
    check("mid tap0 alu_b", 32'(b16), 32'd1);
    check("mid tap0 op", 32'(op16), 32'd1);
    check("mid tap0 busy", 32'(busy16), 32'd1);
    for (int i = 0; i < 4; i++) tick();
    check("mid tap4 alu_b", 32'(b16), 32'd5);
    check("mid tap4 alu_a", 32'(a16), 32'd0);
    rst = 1'b0;
    tick();
    rst = 1'b1;
    check("mid busy", 32'(busy16), 32'd0);
    check("mid op", 32'(op16), 32'd0);
    for (int i = 0; i < 30; i++) tick();
    check("mid no out_valid", n_ov16, base);
    check("mid out_data", od16, 32'd0);
    wr_coef(0, 16'd3);
    for (int k = 1; k < 16; k++) wr_coef(k, 16'd1);
    apply_sample(16'd1, 32'd3, "post-mid");

    // NTAPS=12 build: out-of-range addresses are ignored
    do_reset();
    sel_small = 1'b1;
    for (int k = 0; k < 12; k++) wr_coef(k, 16'(k + 1));
    wr_coef(13, 16'h0100);
    wr_coef(12, 16'h0200);
    wr_coef(15, 16'h0400);
    for (int k = 0; k < 12; k++) begin
      apply_sample((k == 0) ? 16'd1 : 16'd0, 32'(k + 1), $sformatf("n12_%0d", k));
    end
    sel_small = 1'b0;

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/fir_tap_sequencer.md
Name: fir_tap_sequencer

Overview:
Upstream control stage that feeds the FIR core's shared multiply/add ALU. It holds the sample delay line and coefficient bank and accepts one input sample per handshake. For each sample it issues one signed multiply per tap to the ALU, accumulates the returned products, and emits one 32-bit filter output y[n] = sum c[k]*x[n-k].

Parameters:
NTAPS, 16, number of taps (delay-line depth and coefficient count); minimum 2.
DW, 16, sample and coefficient width, signed two's complement.
AW, 32, ALU result width and accumulator/output width.
ALU_LAT, 2, cycles from operands presented to the product being valid on alu_result; minimum 1.

Ports:
clk  in  1  single system clock, all logic on rising edge.
rst  in  1  synchronous, active-low reset.
coef_we  in  1  coefficient write strobe.
coef_addr  in  $clog2(NTAPS)  coefficient index k.
coef_wdata  in  DW  coefficient value.
in_valid  in  1  input sample valid.
in_data  in  DW  input sample x[n].
in_ready  out  1  block can accept a sample.
alu_a  out  DW  multiplier operand (sample).
alu_b  out  DW  multiplier operand (coefficient).
alu_op_sel  out  2  ALU op: 2'b01 multiply while issuing, 2'b00 otherwise.
alu_result  in  AW  ALU product, returned ALU_LAT cycles after issue.
out_valid  out  1  one-cycle pulse, out_data is new.
out_data  out  AW  filter output, held until the next out_valid.
busy  out  1  high in every state other than IDLE.

Behaviour:
- Reset (rst==0 at a clock edge) clears the following to 0: delay line x[0..NTAPS-1], coefficients c[0..NTAPS-1], accumulator, tap counter, latency tag pipe, out_data, out_valid, alu_a, alu_b and alu_op_sel. The FSM goes to IDLE. in_ready is 0 while rst==0.
- Reset mid-operation abandons the sample in flight. No out_valid is produced for it, and any late alu_result is ignored because the tag pipe is cleared.
- FSM states: IDLE, ISSUE, DRAIN, DONE.
- IDLE: in_ready=1.
  - An edge with in_valid&in_ready accepts the sample: the delay line shifts (x[k]<=x[k-1], x[0]<=in_data), the accumulator clears to 0, the tap counter is set to 0, and the FSM goes to ISSUE.
- ISSUE: lasts exactly NTAPS cycles.
  - In cycle k: alu_a=x[k], alu_b=c[k], alu_op_sel=2'b01, and a valid tag enters an ALU_LAT-deep shift pipe.
  - After k==NTAPS-1 the FSM goes to DRAIN.
- DRAIN: lasts exactly ALU_LAT cycles. Operands are driven to 0 and alu_op_sel=2'b00. The FSM then goes to DONE.
- Accumulation: in any cycle where the tag pipe output is 1, acc <= acc + alu_result at that edge.
  - Signed AW-bit addition, wrap-around modulo 2^AW, no saturation.
- DONE: for one cycle, out_valid=1 and out_data=acc (the final sum). The FSM then returns to IDLE.
- Outputs are registered. in_ready=0 in ISSUE, DRAIN and DONE.
- Latency: the accept edge is E. ISSUE occupies cycles E+1..E+NTAPS and DRAIN the next ALU_LAT cycles. out_valid is high in cycle E+NTAPS+ALU_LAT+1, which is 19 cycles for the default parameters. Sustained throughput is one sample per NTAPS+ALU_LAT+2 cycles.
- in_valid while busy is not accepted. The sample must be held by the producer; no drop and no queue.
- Coefficient writes:
  - c[coef_addr]<=coef_wdata only when coef_we=1, busy=0 and coef_addr<NTAPS. Otherwise the write is silently ignored.
  - A write in the same IDLE cycle as a sample accept is applied and is used by that sample.
- Multiplication is performed by the ALU (signed DW×DW→AW). This block never sign-extends products itself.

Test Plan:
- Impulse: c[k]=k+1 for k=0..15, then inputs 1,0,0,…(16 samples) -> out_data sequence 1,2,…,16. Each out_valid arrives exactly 19 cycles after its accept edge, with in_ready=0 throughout.
- Overflow wrap: all c=0x7FFF, sixteen inputs of 0x7FFF -> the 16th output is 0xFFF00010 (-1048560 signed).
- Signed: c[0]=-2, other coefficients 0, input -3 -> out_data=6. A next input of 5 -> out_data=-10 (0xFFFFFFF6).
- Backpressure/coef lockout: hold in_valid=1 with data 7 throughout a busy period -> exactly one accept per IDLE visit. A coef_we to c[0] during ISSUE leaves c[0] unchanged, verified by the next impulse output.
- Reset mid-ISSUE: pull rst low in the 5th ISSUE cycle -> no out_valid, and out_data=0. A subsequent impulse with c[0]=3 yields 3, with no residue from the old delay line.
- Out-of-range write: coef_addr width widened in a NTAPS=12 build, write addr 13 -> no coefficient changes, and impulse outputs match the previously loaded bank.
